// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one bit
// per clock. bcd_o holds the last completed result for the 8-digit scanner.
// Optional macro BIN2BCD_OVF_SAT_EN: saturate to 99999999 and raise ovf_o
// for inputs >= 100_000_000; otherwise the result is bin mod 10^8.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [BIN_WIDTH-1:0] bin_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          bcd_o,
  output logic                 ovf_o
);

  localparam int CNT_WIDTH = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state, state_next;
  logic [BIN_WIDTH-1:0] shift, shift_next;
  logic [31:0]          work, work_next, adj;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 busy_next, done_next;
  logic [31:0]          bcd_next;
  logic                 accept;

  assign accept = (state == IDLE) && start_i;

`ifdef BIN2BCD_OVF_SAT_EN
  logic flag;
  logic big;

  // Inputs narrower than 27 bits can never reach 10^8, so no comparator.
  generate
    if (BIN_WIDTH > 26) begin : g_cmp
      assign big = (32'(bin_i) >= 32'd100_000_000);
    end else begin : g_nocmp
      assign big = 1'b0;
    end
  endgenerate

  // Overflow flag captured on accept, published to ovf_o on the DONE edge.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      flag  <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      if (accept)        flag  <= big;
      if (state == DONE) ovf_o <= flag;
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

  // Add 3 to every work digit >= 5 ahead of the shift.
  always_comb begin
    adj = work;
    for (int unsigned i = 0; i < 8; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath/output next values.
  always_comb begin
    state_next = state;
    shift_next = shift;
    work_next  = work;
    cnt_next   = cnt;
    busy_next  = busy_o;
    done_next  = 1'b0;
    bcd_next   = bcd_o;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          shift_next = bin_i;
          work_next  = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        // The bit leaving work[31] is dropped, giving bin mod 10^8.
        work_next  = {adj[30:0], shift[BIN_WIDTH-1]};
        shift_next = shift << 1;
        cnt_next   = cnt + 1'b1;
        if (cnt == CNT_WIDTH'(BIN_WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
`ifdef BIN2BCD_OVF_SAT_EN
        bcd_next = flag ? 32'h9999_9999 : work;
`else
        bcd_next = work;
`endif
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      shift  <= '0;
      work   <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      bcd_o  <= '0;
    end else begin
      state  <= state_next;
      shift  <= shift_next;
      work   <= work_next;
      cnt    <= cnt_next;
      busy_o <= busy_next;
      done_o <= done_next;
      bcd_o  <= bcd_next;
    end
  end

endmodule
